// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, RAM handshake state and the
// memory arbiter's grant state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// A grant is held for the whole RAM transaction; data has priority except
// when a bounded streak of data completions has starved a pending fetch.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int    MAX_DSTREAK = 4,
   parameter word_t ERR_WORD    = 32'hBAD1BAD1
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      memerr
);

   localparam int            SW   = $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

   arb_state_t    state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          memerr_q, memerr_d;
   logic          dreq, fin, i_done, d_done;
   word_t         rdata;

   // RAM strobes, completion handshakes, streak/error next-state and arbitration
   always_comb begin
      dreq     = dREN | dWEN;
      fin      = (ramstate == ACCESS) || (ramstate == ERROR);
      rdata    = (ramstate == ERROR) ? ERR_WORD : ramload;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      i_done   = 1'b0;
      d_done   = 1'b0;

      // Completion is defined by the RAM alone: a requester that lets go in
      // the very cycle the RAM finishes still gets its completion pulse.
      case (state_q)
         IGRANT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (fin) begin
               i_done = 1'b1;
               iwait  = 1'b0;
               iload  = rdata;
            end
         end
         DGRANT: begin
            ramaddr = daddr;
            if (dWEN) begin
               ramWEN   = 1'b1;
               ramstore = dstore;
            end else begin
               ramREN   = 1'b1;
            end
            if (fin) begin
               d_done = 1'b1;
               dwait  = 1'b0;
               dload  = rdata;
            end
         end
         default: ;
      endcase

      streak_d = streak_q;
      if (!iREN || i_done)
         streak_d = '0;
      else if (d_done && streak_q != SMAX)
         streak_d = streak_q + 1'b1;

      memerr_d = memerr_q | ((i_done | d_done) && (ramstate == ERROR));

      // Arbitrate on the post-completion streak so the data completion that
      // reaches the limit already hands the next grant to the fetch.
      state_d = state_q;
      if (state_q == IDLE || i_done || d_done) begin
         if (dreq && !(iREN && streak_d == SMAX))
            state_d = DGRANT;
         else if (iREN)
            state_d = IGRANT;
         else
            state_d = IDLE;
      end else if ((state_q == IGRANT && !iREN) || (state_q == DGRANT && !dreq)) begin
         state_d = IDLE;
      end

      memerr = memerr_q;
   end

   // Grant state machine
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Anti-starvation streak and sticky error flag
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         streak_q <= '0;
         memerr_q <= 1'b0;
      end else begin
         streak_q <= streak_d;
         memerr_q <= memerr_d;
      end
   end

endmodule
